// File: rtl/s2p_frame.sv
// s2p_frame: serial-to-parallel frame receiver.
// Shifts one bit per enable cycle and assembles frames of 1..WIDTH bits, MSB-first
// or LSB-first. Length and bit order are latched at frame start. Each completed
// frame goes to a ready/valid output register. A completed frame that finds the
// register still full is dropped and raises a sticky overrun flag.
// Optional feature macro: S2P_PARITY_EN. When it is defined, each frame carries a
// trailing odd-parity bit. That bit is checked and reported on parity_err, and it
// is never stored in data_out.
module s2p_frame #(
    parameter int WIDTH = 16,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_in,
    input  logic             enable,
    input  logic [LEN_W-1:0] len,
    input  logic             msb_first,
    input  logic             clear,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [LEN_W-1:0] count,
    output logic             overrun,
    output logic             parity_err
);

    logic [WIDTH-1:0] r_shreg;
    logic [LEN_W-1:0] r_count;
    logic [LEN_W-1:0] r_len;
    logic             r_msb;
    logic [WIDTH-1:0] r_data_out;
    logic             r_valid;
    logic             r_overrun;
    logic             r_perr;

    logic             w_start;
    logic [LEN_W-1:0] w_len_lat;
    logic [LEN_W-1:0] w_len;
    logic             w_msb;
    logic             w_is_par_bit;
    logic             w_last;
    logic [WIDTH-1:0] w_shreg_next;
    logic             w_done;
    logic             w_load;
    logic             w_accept;

    // Frame bookkeeping: the first bit of a frame uses the live len/msb_first,
    // and every later bit uses the copies latched on that first bit.
    always_comb begin
        w_start   = (r_count == '0);
        w_len_lat = len;
        if (len == '0 || len > LEN_W'(WIDTH)) begin
            w_len_lat = LEN_W'(WIDTH);
        end
        w_len = w_start ? w_len_lat : r_len;
        w_msb = w_start ? msb_first : r_msb;
`ifdef S2P_PARITY_EN
        // The bit after the last data bit is the parity bit.
        w_is_par_bit = (r_count == w_len);
        w_last       = w_is_par_bit;
`else
        w_is_par_bit = 1'b0;
        w_last       = (r_count == w_len - LEN_W'(1));
`endif
    end

    // Shift register contents after consuming data_in. Because the register
    // starts every frame at zero, the result is right-aligned and zero-extended.
    always_comb begin
        w_shreg_next = r_shreg;
        if (!w_is_par_bit) begin
            if (w_msb) begin
                w_shreg_next = {r_shreg[WIDTH-2:0], data_in};
            end else begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (LEN_W'(i) == r_count) begin
                        w_shreg_next[i] = data_in;
                    end
                end
            end
        end
    end

    assign w_done   = enable && !clear && w_last;
    assign w_accept = r_valid && out_ready;
    assign w_load   = w_done && (!r_valid || out_ready);

`ifdef S2P_PARITY_EN
    logic r_par;
    logic w_par;

    assign w_par = (w_start ? 1'b0 : r_par) ^ data_in;

    // Running XOR of the frame bits received so far, restarted for each frame.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_par <= 1'b0;
        end else if (clear || (enable && w_last)) begin
            r_par <= 1'b0;
        end else if (enable) begin
            r_par <= w_par;
        end
    end
`endif

    // Bit collection, the output register handshake and the overrun flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shreg    <= '0;
            r_count    <= '0;
            r_len      <= '0;
            r_msb      <= 1'b0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
            r_perr     <= 1'b0;
        end else begin
            if (clear) begin
                r_count <= '0;
                r_shreg <= '0;
            end else if (enable) begin
                if (w_last) begin
                    r_count <= '0;
                    r_shreg <= '0;
                end else begin
                    r_count <= r_count + LEN_W'(1);
                    r_shreg <= w_shreg_next;
                end
                if (w_start) begin
                    r_len <= w_len_lat;
                    r_msb <= msb_first;
                end
            end

            if (w_load) begin
                r_data_out <= w_shreg_next;
                r_valid    <= 1'b1;
`ifdef S2P_PARITY_EN
                // Odd parity: an even total over data and parity bits is an error.
                r_perr     <= ~w_par;
`else
                r_perr     <= 1'b0;
`endif
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end

            if (clear) begin
                r_overrun <= 1'b0;
            end else if (w_done && !w_load) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign data_out   = r_data_out;
    assign out_valid  = r_valid;
    assign busy       = (r_count != '0);
    assign count      = r_count;
    assign overrun    = r_overrun;
    assign parity_err = r_perr;

endmodule

// File: tb/tb_s2p_frame.sv
// Testbench for s2p_frame (WIDTH=16). Expected frames are pushed to a queue as they
// are sent, and a negedge monitor pops and compares them on each accepted output.
module tb_s2p_frame;

    localparam int WIDTH = 16;
    localparam int LEN_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             data_in = 1'b0;
    logic             enable = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             msb_first = 1'b1;
    logic             clear = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             busy;
    logic [LEN_W-1:0] count;
    logic             overrun;
    logic             parity_err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             perr;
    } exp_t;
    exp_t sb[$];

    s2p_frame #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .enable     (enable),
        .len        (len),
        .msb_first  (msb_first),
        .clear      (clear),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .count      (count),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: an accept happens at the next rising edge.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: data_out=%h with no frame expected", data_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (data_out !== e.data || parity_err !== e.perr) begin
                    n_fail++;
                    $display("FAIL sb_frame: got data=%h perr=%b, expected data=%h perr=%b",
                             data_out, parity_err, e.data, e.perr);
                end
            end
        end
    end

    // Inputs change 2 time units after each rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic stop();
        enable = 1'b0;
    endtask

    // Sends one frame. len/msb_first are scrambled after the first bit to test latching.
    task automatic send_frame(input logic [WIDTH-1:0] val, input int n, input logic [LEN_W-1:0] lenv,
                              input logic msb, input logic flip, input logic keep,
                              input logic ready_last);
        exp_t e;
        int   nb;
        logic [WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < n; i++) m[i] = val[i];
        e.data = m;
`ifdef S2P_PARITY_EN
        e.perr = flip;
        nb = n + 1;
`else
        e.perr = 1'b0;
        nb = n;
`endif
        if (keep) sb.push_back(e);
        for (int i = 0; i < nb; i++) begin
            if (i == 0) begin
                len = lenv;
                msb_first = msb;
            end else begin
                len = LEN_W'(3);
                msb_first = ~msb;
            end
            if (i == n) data_in = (~^m) ^ flip;
            else data_in = msb ? m[n-1-i] : m[i];
            enable = 1'b1;
            if (ready_last && i == nb - 1) out_ready = 1'b1;
            cyc();
        end
        out_ready = 1'b0;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL accept_drop: out_valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic check_idle_zero(input string name);
        n_tests++;
        if (data_out !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || count !== '0 ||
            overrun !== 1'b0 || parity_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: data=%h valid=%b busy=%b count=%0d ovr=%b perr=%b, expected all 0",
                     name, data_out, out_valid, busy, count, overrun, parity_err);
        end
    endtask

    task automatic test_reset();
        cyc();
        cyc();
        check_idle_zero("reset_init");
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in = 1'b1;
            len = LEN_W'(8);
            enable = 1'b1;
            cyc();
        end
        n_tests++;
        if (count !== LEN_W'(5) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_partial: count=%0d busy=%b, expected 5 1", count, busy);
        end
        reset = 1'b0;
        cyc();
        cyc();
        check_idle_zero("reset_mid");
        stop();
        reset = 1'b1;
        cyc();
        send_frame(16'h00B3, 8, LEN_W'(8), 1'b1, 1'b0, 1'b1, 1'b0);
        stop();
        n_tests++;
        if (out_valid !== 1'b1 || data_out !== 16'h00B3) begin
            n_fail++;
            $display("FAIL reset_frame: valid=%b data=%h, expected 1 00b3", out_valid, data_out);
        end
        accept();
    endtask

    task automatic test_lsb_first();
        send_frame(16'h0001, 4, LEN_W'(4), 1'b0, 1'b0, 1'b1, 1'b0);
        stop();
        n_tests++;
        if (out_valid !== 1'b1 || data_out !== 16'h0001 || count !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL lsb_first: valid=%b data=%h count=%0d busy=%b, expected 1 0001 0 0",
                     out_valid, data_out, count, busy);
        end
        accept();
    endtask

    task automatic test_len_clamp();
        send_frame(16'hAAAA, 16, LEN_W'(0), 1'b1, 1'b0, 1'b1, 1'b0);
        stop();
        n_tests++;
        if (out_valid !== 1'b1 || data_out !== 16'hAAAA) begin
            n_fail++;
            $display("FAIL len_clamp0: valid=%b data=%h, expected 1 aaaa", out_valid, data_out);
        end
        accept();
        send_frame(16'h1234, 16, LEN_W'(17), 1'b0, 1'b0, 1'b1, 1'b0);
        stop();
        n_tests++;
        if (data_out !== 16'h1234) begin
            n_fail++;
            $display("FAIL len_clamp17: data=%h, expected 1234", data_out);
        end
        accept();
    endtask

    task automatic test_backpressure();
        send_frame(16'h005A, 8, LEN_W'(8), 1'b1, 1'b0, 1'b1, 1'b0);
        send_frame(16'h003C, 8, LEN_W'(8), 1'b1, 1'b0, 1'b0, 1'b0);
        stop();
        n_tests++;
        if (out_valid !== 1'b1 || data_out !== 16'h005A || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure: valid=%b data=%h ovr=%b, expected 1 005a 1",
                     out_valid, data_out, overrun);
        end
        accept();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        n_tests++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_overrun: ovr=%b, expected 0", overrun);
        end
    endtask

    task automatic test_accept_and_complete();
        send_frame(16'h005A, 8, LEN_W'(8), 1'b1, 1'b0, 1'b1, 1'b0);
        send_frame(16'h003C, 8, LEN_W'(8), 1'b1, 1'b0, 1'b1, 1'b1);
        stop();
        n_tests++;
        if (out_valid !== 1'b1 || data_out !== 16'h003C || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL accept_complete: valid=%b data=%h ovr=%b, expected 1 003c 0",
                     out_valid, data_out, overrun);
        end
        accept();
    endtask

    task automatic test_clear_mid_frame();
        for (int i = 0; i < 3; i++) begin
            data_in = 1'b1;
            len = LEN_W'(8);
            enable = 1'b1;
            cyc();
        end
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        stop();
        n_tests++;
        if (count !== '0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_mid: count=%0d busy=%b valid=%b, expected 0 0 0", count, busy, out_valid);
        end
        send_frame(16'h0096, 8, LEN_W'(8), 1'b0, 1'b0, 1'b1, 1'b0);
        stop();
        n_tests++;
        if (data_out !== 16'h0096) begin
            n_fail++;
            $display("FAIL clear_next: data=%h, expected 0096", data_out);
        end
        accept();
    endtask

    task automatic test_parity();
`ifdef S2P_PARITY_EN
        send_frame(16'h0007, 8, LEN_W'(8), 1'b1, 1'b0, 1'b1, 1'b0);
        stop();
        n_tests++;
        if (parity_err !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_good: perr=%b, expected 0", parity_err);
        end
        accept();
        send_frame(16'h0007, 8, LEN_W'(8), 1'b1, 1'b1, 1'b1, 1'b0);
        stop();
        n_tests++;
        if (parity_err !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_bad: perr=%b, expected 1", parity_err);
        end
        accept();
`else
        n_tests++;
        if (parity_err !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_tied: perr=%b, expected 0", parity_err);
        end
`endif
    endtask

    initial begin
        #2;
        test_reset();
        test_lsb_first();
        test_len_clamp();
        test_backpressure();
        test_accept_and_complete();
        test_clear_mid_frame();
        test_parity();
        cyc();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d frames not delivered, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
